// File: rtl/rand_weight_init.sv
// Random weight initialiser: seeds and steps an external LFSR/CA generator, scales each
// 32-bit sample into a signed fixed-point weight and writes one weight per memory address.
module rand_weight_init #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int WARMUP    = 64,
    parameter int SHIFT     = 4,
    parameter int SEED_W    = 43
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SEED_W-1:0] seed_in,
    output logic [SEED_W-1:0] prng_seed,
    output logic              prng_reset,
    output logic              prng_enable,
    output logic              prng_fetch,
    input  logic [31:0]       prng_sample,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StWarm,
        StFetch,
        StCapt,
        StWrite,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic              prng_reset_q, prng_enable_q, prng_fetch_q;
    logic              mem_we_q, busy_q, done_q;

    // Low DATA_W bits of the sample taken as signed, then arithmetic shift sets the range.
    logic signed [DATA_W-1:0] sample_trunc;
    logic signed [DATA_W-1:0] sample_scaled;

    assign sample_trunc  = prng_sample[DATA_W-1:0];
    assign sample_scaled = sample_trunc >>> SHIFT;

    if (DATA_W < 32) begin : g_unused_sample
        logic unused_sample_bits;
        assign unused_sample_bits = ^prng_sample[31:DATA_W];
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        seed_d     = seed_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    seed_d  = seed_in;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                warm_cnt_d = '0;
                addr_d     = '0;
                state_d    = (WARMUP > 0) ? StWarm : StFetch;
            end
            StWarm: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = StFetch;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            StFetch: state_d = StCapt;
            StCapt: begin
                wdata_d = sample_scaled;
                state_d = StWrite;
            end
            StWrite: begin
                if (mem_ready) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control outputs are registered copies decoded from the next state, so each one is
    // aligned with the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            warm_cnt_q    <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            seed_q        <= '0;
            prng_reset_q  <= 1'b0;
            prng_enable_q <= 1'b0;
            prng_fetch_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            warm_cnt_q    <= warm_cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            seed_q        <= seed_d;
            prng_reset_q  <= (state_d == StSeed);
            prng_enable_q <= (state_d == StWarm) || (state_d == StFetch);
            prng_fetch_q  <= (state_d == StFetch);
            mem_we_q      <= (state_d == StWrite);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
        end
    end

    assign prng_seed   = seed_q;
    assign prng_reset  = prng_reset_q;
    assign prng_enable = prng_enable_q;
    assign prng_fetch  = prng_fetch_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rand_weight_init.sv
// Directed bench for rand_weight_init: behavioural generator stand-in, write/done monitor
// and one task per scenario with inline expected-value comparisons.
module tb_rand_weight_init;

    localparam logic [42:0] TAPS = 43'h6A35C7E91B4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [42:0] seed_in = '0;
    logic        mem_ready = 1'b1;
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;

    logic [42:0] prng_seed0, prng_seed1;
    logic        prng_reset0, prng_enable0, prng_fetch0;
    logic        prng_reset1, prng_enable1, prng_fetch1;
    logic [31:0] prng_sample0, prng_sample1;
    logic        mem_we0, mem_we1, busy0, busy1, done0, done1;
    logic [9:0]  mem_addr0, mem_addr1;
    logic [15:0] mem_wdata0, mem_wdata1;

    logic [42:0] gstate0 = '0, gstate1 = '0;
    logic [31:0] gsample0 = '0, gsample1 = '0;

    int errors = 0;
    int checks = 0;

    logic [9:0]  wr_addr [0:127];
    logic [15:0] wr_data [0:127];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [9:0]  wr1_addr [0:15];
    logic [15:0] wr1_data [0:15];
    int          wr1_cnt = 0;
    int          done1_cnt = 0;

    logic [15:0] exp_w [0:3];
    logic [15:0] golden [0:3];

    always #5 clock = ~clock;

    rand_weight_init #(
        .DATA_W(16), .ADDR_W(10), .NUM_WORDS(4), .WARMUP(2), .SHIFT(4), .SEED_W(43)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .seed_in(seed_in),
        .prng_seed(prng_seed0), .prng_reset(prng_reset0), .prng_enable(prng_enable0),
        .prng_fetch(prng_fetch0), .prng_sample(prng_sample0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_ready(mem_ready),
        .busy(busy0), .done(done0)
    );

    rand_weight_init #(
        .DATA_W(16), .ADDR_W(10), .NUM_WORDS(1), .WARMUP(0), .SHIFT(4), .SEED_W(43)
    ) dut_w0 (
        .clock(clock), .reset(reset), .start(start1), .seed_in(seed_in),
        .prng_seed(prng_seed1), .prng_reset(prng_reset1), .prng_enable(prng_enable1),
        .prng_fetch(prng_fetch1), .prng_sample(prng_sample1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_ready(1'b1),
        .busy(busy1), .done(done1)
    );

    function automatic logic [42:0] adv(input logic [42:0] s);
        logic [42:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ TAPS;
        return t;
    endfunction

    function automatic logic [31:0] low32(input logic [42:0] s);
        return s[31:0];
    endfunction

    function automatic logic [15:0] scale_ref(input logic [31:0] x);
        logic signed [15:0] v;
        v = x[15:0];
        return v >>> 4;
    endfunction

    // Generator stand-in: reset loads the seed, enable steps, fetch captures the stepped value.
    always @(posedge clock) begin
        if (prng_reset0) gstate0 <= prng_seed0;
        else if (prng_enable0) gstate0 <= adv(gstate0);
        if (prng_fetch0) gsample0 <= low32(adv(gstate0));
        if (prng_reset1) gstate1 <= prng_seed1;
        else if (prng_enable1) gstate1 <= adv(gstate1);
        if (prng_fetch1) gsample1 <= low32(adv(gstate1));
    end

    assign prng_sample0 = force_en ? force_val : gsample0;
    assign prng_sample1 = gsample1;

    always @(posedge clock) begin
        if (!reset) begin
            if (mem_we0 && mem_ready) begin
                if (wr_cnt < 128) begin
                    wr_addr[wr_cnt] <= mem_addr0;
                    wr_data[wr_cnt] <= mem_wdata0;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (done0) done_cnt <= done_cnt + 1;
            if (mem_we1) begin
                if (wr1_cnt < 16) begin
                    wr1_addr[wr1_cnt] <= mem_addr1;
                    wr1_data[wr1_cnt] <= mem_wdata1;
                end
                wr1_cnt <= wr1_cnt + 1;
            end
            if (done1) done1_cnt <= done1_cnt + 1;
        end
    end

    task automatic compute_exp(input logic [42:0] seed, input int warm, input int n);
        logic [42:0] s;
        s = seed;
        for (int i = 0; i < warm; i++) s = adv(s);
        for (int i = 0; i < n; i++) begin
            s = adv(s);
            exp_w[i] = scale_ref(low32(s));
        end
    endtask

    // Ends on the negedge of the first busy cycle.
    task automatic do_start(input logic [42:0] s, input bit which);
        @(negedge clock);
        seed_in = s;
        if (which) start1 = 1'b1;
        else start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done0(inout int cyc);
        while (done0 !== 1'b1 && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({prng_seed0, prng_reset0, prng_enable0, prng_fetch0, mem_we0, mem_addr0,
             mem_wdata0, busy0, done0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got seed=%h rst=%b en=%b fe=%b we=%b a=%h d=%h b=%b d=%b expected all 0",
                     prng_seed0, prng_reset0, prng_enable0, prng_fetch0, mem_we0, mem_addr0,
                     mem_wdata0, busy0, done0);
        end
        checks++;
        if ({prng_seed1, prng_reset1, prng_enable1, prng_fetch1, mem_we1, mem_addr1,
             mem_wdata1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_w0: second instance outputs not all 0");
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        int base, dbase, cyc;
        base  = wr_cnt;
        dbase = done_cnt;
        compute_exp(43'h1, 2, 4);
        for (int i = 0; i < 4; i++) golden[i] = exp_w[i];
        do_start(43'h1, 1'b0);
        checks++;
        if (busy0 !== 1'b1 || prng_reset0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_seed_cycle: got busy=%b prng_reset=%b expected 1 1", busy0, prng_reset0);
        end
        cyc = 1;
        wait_done0(cyc);
        checks++;
        if (cyc !== 16) begin
            errors++;
            $display("FAIL basic_run_length: got %0d expected 16", cyc);
        end
        @(negedge clock);
        checks++;
        if (wr_cnt - base !== 4) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected 4", wr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr[base+i] !== 10'(i) || wr_data[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, wr_addr[base+i], wr_data[base+i], 10'(i), exp_w[i]);
            end
        end
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || done_cnt - dbase !== 1 || mem_addr0 !== 10'd3) begin
            errors++;
            $display("FAIL basic_after_done: got busy=%b done=%b pulses=%0d addr=%h expected 0 0 1 003",
                     busy0, done0, done_cnt - dbase, mem_addr0);
        end
    endtask

    task automatic test_scaling;
        logic [31:0] vin  [0:3];
        logic [15:0] vexp [0:3];
        int base, cyc;
        vin[0] = 32'h0000_8000; vexp[0] = 16'hF800;
        vin[1] = 32'h1234_7FF0; vexp[1] = 16'h07FF;
        vin[2] = 32'hFFFF_FFFF; vexp[2] = 16'hFFFF;
        vin[3] = 32'h0000_0000; vexp[3] = 16'h0000;
        for (int v = 0; v < 4; v++) begin
            force_en  = 1'b1;
            force_val = vin[v];
            base = wr_cnt;
            do_start(43'h7, 1'b0);
            cyc = 1;
            wait_done0(cyc);
            @(negedge clock);
            checks++;
            if (wr_cnt - base !== 4 || wr_data[base] !== vexp[v] || wr_data[base+3] !== vexp[v]) begin
                errors++;
                $display("FAIL scaling_%h: got n=%0d first=%h last=%h expected n=4 data=%h",
                         vin[v], wr_cnt - base, wr_data[base], wr_data[base+3], vexp[v]);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_backpressure;
        int base, cyc;
        bit found;
        base  = wr_cnt;
        found = 1'b0;
        do_start(43'h1, 1'b0);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (mem_we0 === 1'b1 && mem_addr0 === 10'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bp_reach_write1: got no write at addr 1 expected one within 100 cycles");
        end
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({mem_we0, mem_addr0, mem_wdata0, prng_enable0, prng_fetch0} !==
                {1'b1, 10'd1, golden[1], 2'b00}) begin
                errors++;
                $display("FAIL bp_stall%0d: got we=%b a=%h d=%h en=%b fe=%b expected 1 001 %h 0 0",
                         k, mem_we0, mem_addr0, mem_wdata0, prng_enable0, prng_fetch0, golden[1]);
            end
            @(negedge clock);
        end
        mem_ready = 1'b1;
        cyc = 0;
        wait_done0(cyc);
        @(negedge clock);
        checks++;
        if (wr_cnt - base !== 4 || wr_data[base] !== golden[0] || wr_data[base+1] !== golden[1] ||
            wr_data[base+2] !== golden[2] || wr_data[base+3] !== golden[3]) begin
            errors++;
            $display("FAIL bp_final_data: got n=%0d %h %h %h %h expected 4 %h %h %h %h",
                     wr_cnt - base, wr_data[base], wr_data[base+1], wr_data[base+2],
                     wr_data[base+3], golden[0], golden[1], golden[2], golden[3]);
        end
    endtask

    task automatic test_start_busy;
        int base, dbase, cyc;
        bit found;
        base  = wr_cnt;
        dbase = done_cnt;
        found = 1'b0;
        do_start(43'h1, 1'b0);
        @(negedge clock);
        checks++;
        if (prng_enable0 !== 1'b1 || prng_fetch0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_warm: got en=%b fe=%b expected 1 0", prng_enable0, prng_fetch0);
        end
        seed_in = 43'h5A5A5A;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (mem_we0 === 1'b1) found = 1'b1;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        wait_done0(cyc);
        repeat (10) @(negedge clock);
        checks++;
        if (prng_seed0 !== 43'h1) begin
            errors++;
            $display("FAIL busy_seed_kept: got %h expected %h", prng_seed0, 43'h1);
        end
        checks++;
        if (wr_cnt - base !== 4 || done_cnt - dbase !== 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_counts: got writes=%0d dones=%0d busy=%b expected 4 1 0",
                     wr_cnt - base, done_cnt - dbase, busy0);
        end
        checks++;
        if (wr_data[base+3] !== golden[3] || wr_addr[base+3] !== 10'd3) begin
            errors++;
            $display("FAIL busy_last_word: got a=%h d=%h expected 003 %h",
                     wr_addr[base+3], wr_data[base+3], golden[3]);
        end
    endtask

    task automatic test_reset_mid;
        int base, dbase, cyc;
        bit found;
        base  = wr_cnt;
        dbase = done_cnt;
        found = 1'b0;
        do_start(43'h1, 1'b0);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (mem_we0 === 1'b1 && mem_addr0 === 10'd2) found = 1'b1;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({prng_seed0, prng_reset0, prng_enable0, prng_fetch0, mem_we0, mem_addr0,
             mem_wdata0, busy0, done0} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got we=%b a=%h d=%h busy=%b done=%b expected all 0",
                     mem_we0, mem_addr0, mem_wdata0, busy0, done0);
        end
        reset = 1'b0;
        repeat (8) @(negedge clock);
        checks++;
        if (done_cnt - dbase !== 0 || wr_cnt - base !== 2 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got dones=%0d writes=%0d busy=%b expected 0 2 0",
                     done_cnt - dbase, wr_cnt - base, busy0);
        end
        base = wr_cnt;
        do_start(43'h1, 1'b0);
        cyc = 1;
        wait_done0(cyc);
        @(negedge clock);
        checks++;
        if (cyc !== 16 || wr_cnt - base !== 4 || wr_data[base] !== golden[0] ||
            wr_data[base+1] !== golden[1] || wr_data[base+2] !== golden[2] ||
            wr_data[base+3] !== golden[3]) begin
            errors++;
            $display("FAIL midreset_rerun: got cyc=%0d n=%0d %h %h %h %h expected 16 4 %h %h %h %h",
                     cyc, wr_cnt - base, wr_data[base], wr_data[base+1], wr_data[base+2],
                     wr_data[base+3], golden[0], golden[1], golden[2], golden[3]);
        end
    endtask

    task automatic test_warmup0;
        int base, dbase, cyc;
        base  = wr1_cnt;
        dbase = done1_cnt;
        compute_exp(43'h123456789AB, 0, 1);
        do_start(43'h123456789AB, 1'b1);
        @(negedge clock);
        checks++;
        if (prng_fetch1 !== 1'b1 || prng_enable1 !== 1'b1) begin
            errors++;
            $display("FAIL w0_direct_fetch: got fe=%b en=%b expected 1 1", prng_fetch1, prng_enable1);
        end
        cyc = 2;
        while (done1 !== 1'b1 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL w0_run_length: got %0d expected 5", cyc);
        end
        @(negedge clock);
        checks++;
        if (wr1_cnt - base !== 1 || wr1_addr[base] !== 10'd0 || wr1_data[base] !== exp_w[0] ||
            done1_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL w0_write: got n=%0d a=%h d=%h dones=%0d expected 1 000 %h 1",
                     wr1_cnt - base, wr1_addr[base], wr1_data[base], done1_cnt - dbase, exp_w[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scaling();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_warmup0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
